uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter byte port (enq ready/valid, 8-bit) between NREQ requesters.
//  Round-robin grant, held for a whole packet (until a beat with last=1 is accepted).
//  Sits between the requesters and the UART transmitter enq interface.
// PARAMETERS
//  NREQ     4     number of requesters (2..8)
//  TIMEOUT  4096  idle cycles mid-packet before forced release (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  req_valid      in   NREQ    per-requester byte valid
//  req_bits       in   NREQ*8  per-requester byte; requester i uses [8i+7:8i]
//  req_last       in   NREQ    byte is the final byte of the packet
//  req_ready      out  NREQ    per-requester accept
//  enq_valid      out  1       to UART tx enq_valid
//  enq_bits       out  8       to UART tx enq_bits
//  enq_ready      in   1       from UART tx enq_ready
//  grant_id       out  clog2(NREQ)  current/last owner index
//  busy           out  1       packet in progress (state LOCK)
//  timeout_err    out  1       1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, last_grant=NREQ-1, grant_id=0, busy=0,
//   enq_valid=0, enq_bits=0, req_ready=0, timeout_err=0, idle counter=0.
//  States: IDLE, LOCK.
//  IDLE: enq_valid=0, req_ready=0. If any req_valid: pick the first valid index
//   after last_grant (wrapping modulo NREQ); register grant_id; go to LOCK next cycle.
//   Arbitration latency is 1 cycle; no byte transfers in IDLE.
//  LOCK (owner g=grant_id): enq_valid=req_valid[g], enq_bits=req_bits[g],
//   req_ready[g]=enq_ready, all other req_ready=0. Pure combinational path, no bubble.
//   Beat = enq_valid & enq_ready. Beat with req_last[g]=1: last_grant<=g, go to IDLE.
//   Back-to-back packets from different requesters therefore have exactly one idle cycle.
//  enq_bits is 0 whenever enq_valid=0 (no X propagation to the transmitter).
//  Other requesters' valid/last are ignored while LOCK; their bytes are never dropped.
//  Owner deasserting req_valid mid-packet: grant is held (see CONFIGURATION).
//  Owner's req_last with req_valid=0 has no effect.
//  Single requester: same requester regranted each packet after the idle cycle.
//  Reset mid-packet: immediately IDLE, enq_valid=0; partial packet is abandoned.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: idle counter, width clog2(TIMEOUT+1), clears on
//   entry to LOCK and on every beat; increments each LOCK cycle with no beat.
//   Reaching TIMEOUT: go to IDLE, last_grant<=g, timeout_err=1 for one cycle.
//   A beat in the same cycle the count would reach TIMEOUT wins (no release).
//  Not defined: no counter, timeout_err tied 0, grant held indefinitely.
// STRUCTURE
//  Package uart_arb_pkg: state enum {IDLE, LOCK}, BYTE_W=8, function idx_w(n)=clog2(n).
//  Sub-module rr_pick: combinational, inputs req[NREQ] and last[idx_w];
//   outputs any and sel[idx_w] (first set bit after last, wrapping).
//  Top holds FSM, grant register, output muxes, optional timeout counter.
// TESTING
//  Reset: hold reset=0 with req_valid=4'b1111 -> enq_valid=0, req_ready=0, busy=0.
//  RR order: all 4 valid, each sends 1-byte packet (last=1), enq_ready=1 ->
//   grants 0,1,2,3,0, one idle cycle between packets.
//  Lock: req0 sends 3 bytes 0x41,0x42,0x43(last) while req1 valid -> enq_bits
//   0x41,0x42,0x43 uninterrupted, then req1 granted.
//  Backpressure: enq_ready=0 for 10 cycles mid-packet -> enq_bits stable,
//   req_ready[g]=0, no byte lost or duplicated.
//  Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT=16): owner drops valid after 1 byte ->
//   release after 16 cycles, timeout_err pulse, next requester granted.
//  Async reset mid-packet: assert reset between bytes -> enq_valid=0 immediately.
//   After release, the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   localparam int BYTE_W = 8;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the transmit arbiter, plus grant/status observation.
// Handshake: a byte moves on a rising edge where valid and ready are both 1; valid never waits on ready.
interface uart_tx_arbiter_if
   import uart_arb_pkg::*;
#(
   parameter int NREQ = 4
);
   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*BYTE_W-1:0] req_bits;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        req_ready;
   logic                   enq_valid;
   logic [BYTE_W-1:0]      enq_bits;
   logic                   enq_ready;
   logic [IW-1:0]          grant_id;
   logic                   busy;
   logic                   timeout_err;
   arb_state_e             state;

   modport master (
      input  req_valid, req_bits, req_last, enq_ready,
      output req_ready, enq_valid, enq_bits, grant_id, busy, timeout_err, state
   );

   modport slave (
      output req_valid, req_bits, req_last, enq_ready,
      input  req_ready, enq_valid, enq_bits, grant_id, busy, timeout_err, state
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first set request strictly after index `last`, wrapping modulo NREQ.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            any,
   output logic [IW-1:0]   sel
);

   // Walk from the farthest candidate back to the nearest so the nearest one wins.
   always_comb begin
      any = |req;
      sel = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % NREQ]) begin
            sel = IW'((int'(last) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmit byte port among NREQ requesters.
// Define UART_ARB_TIMEOUT_EN to release a stalled packet owner after TIMEOUT idle cycles.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 4096
) (
   input logic               clk,
   input logic               reset,
   uart_tx_arbiter_if.master bus
);
   localparam int IW = idx_w(NREQ);

   arb_state_e        state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     last_grant_q, last_grant_d;
   logic              pick_any;
   logic [IW-1:0]     pick_sel;
   logic              owner_valid;
   logic              owner_last;
   logic [BYTE_W-1:0] owner_bits;
   logic              beat;
   logic              release_to;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (bus.req_valid),
      .last (last_grant_q),
      .any  (pick_any),
      .sel  (pick_sel)
   );

   assign owner_valid = bus.req_valid[grant_q];
   assign owner_last  = bus.req_last[grant_q];
   assign owner_bits  = bus.req_bits[int'(grant_q)*BYTE_W +: BYTE_W];
   assign beat        = (state_q == LOCK) && owner_valid && bus.enq_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IW'(NREQ - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = LOCK;
               grant_d = pick_sel;
            end
         end
         LOCK: begin
            if ((beat && owner_last) || release_to) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Owner is wired straight through in LOCK; the transmitter never sees stale or X data.
   always_comb begin
      bus.req_ready = '0;
      bus.enq_valid = 1'b0;
      bus.enq_bits  = '0;
      if (state_q == LOCK) begin
         bus.enq_valid          = owner_valid;
         bus.enq_bits           = owner_valid ? owner_bits : '0;
         bus.req_ready[grant_q] = bus.enq_ready;
      end
   end

   assign bus.busy     = (state_q == LOCK);
   assign bus.grant_id = grant_q;
   assign bus.state    = state_q;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic          timeout_err_q;

   // A beat in the cycle the count would reach TIMEOUT clears it instead of releasing.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      release_to = 1'b0;
      if (state_q != LOCK || beat) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
         idle_cnt_d = '0;
         release_to = 1'b1;
      end else begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         idle_cnt_q    <= idle_cnt_d;
         timeout_err_q <= release_to;
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   logic unused_cfg;

   assign release_to      = 1'b0;
   assign bus.timeout_err = 1'b0;
   assign unused_cfg      = (TIMEOUT > 0);
`endif

endmodule
